// File: rtl/padring_pkg.sv
// Shared types and constants for the GPIO pad-ring controller.
package padring_pkg;

  localparam int MODE_W = 2;
  localparam int GUARD_CNT_W = 8;

  typedef enum logic [MODE_W-1:0] {
    FUNC          = 2'd0,
    GUARD_TO_TEST = 2'd1,
    TEST          = 2'd2,
    GUARD_TO_FUNC = 2'd3
  } state_e;

endpackage

// File: rtl/padring_sync.sv
// Single-bit multi-flop synchroniser for asynchronous pad levels.
module padring_sync
  import padring_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/padring_ctrl.sv
// GPIO pad-ring controller: break-before-make arbitration between core and test paths.
// Optional test-mode request debounce is built when PADRING_TM_DEBOUNCE_EN is defined.
module padring_ctrl
  import padring_pkg::*;
#(
  parameter int GPIO_WIDTH      = 15,
  parameter int SYNC_STAGES     = 2,
  parameter int GUARD_CYCLES    = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pad_tm_i,
  input  logic [GPIO_WIDTH-1:0] pad_i,
  output logic [GPIO_WIDTH-1:0] pad_o,
  output logic [GPIO_WIDTH-1:0] pad_oe,
  input  logic [GPIO_WIDTH-1:0] core_o,
  input  logic [GPIO_WIDTH-1:0] core_oe,
  output logic [GPIO_WIDTH-1:0] core_i,
  input  logic [GPIO_WIDTH-1:0] tm_o,
  input  logic [GPIO_WIDTH-1:0] tm_oe,
  output logic [GPIO_WIDTH-1:0] tm_i,
  input  logic                  cfg_valid,
  input  logic [GPIO_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_ready,
  output logic [MODE_W-1:0]     mode,
  output logic                  tm_active
);

  logic                   tm_req;
  logic                   tm_fsm_req;
  logic [GPIO_WIDTH-1:0]  pad_sync;
  logic [GPIO_WIDTH-1:0]  pin_en;
  logic [MODE_W-1:0]      state;
  logic [GUARD_CNT_W-1:0] guard_cnt;
  logic                   in_func;
  logic                   in_test;

  padring_sync #(.STAGES(SYNC_STAGES)) u_tm_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_tm_i),
    .q   (tm_req)
  );

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad_sync
    padring_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pad_i[i]),
      .q   (pad_sync[i])
    );
  end

`ifdef PADRING_TM_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;
  logic            tm_req_db;

  // A new request level is adopted only after it has held for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt    <= '0;
      tm_req_db <= 1'b0;
    end else if (tm_req == tm_req_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt    <= '0;
      tm_req_db <= tm_req;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign tm_fsm_req = tm_req_db;
`else
  assign tm_fsm_req = tm_req;
`endif

  // Guard windows always run to completion; the request is only looked at in FUNC/TEST.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FUNC;
      guard_cnt <= '0;
    end else begin
      case (state)
        FUNC: begin
          if (tm_fsm_req) begin
            state     <= GUARD_TO_TEST;
            guard_cnt <= GUARD_CNT_W'(GUARD_CYCLES - 1);
          end
        end
        GUARD_TO_TEST: begin
          if (guard_cnt == '0) state <= TEST;
          else guard_cnt <= guard_cnt - GUARD_CNT_W'(1);
        end
        TEST: begin
          if (!tm_fsm_req) begin
            state     <= GUARD_TO_FUNC;
            guard_cnt <= GUARD_CNT_W'(GUARD_CYCLES - 1);
          end
        end
        default: begin
          if (guard_cnt == '0) state <= FUNC;
          else guard_cnt <= guard_cnt - GUARD_CNT_W'(1);
        end
      endcase
    end
  end

  assign in_func   = (state == FUNC);
  assign in_test   = (state == TEST);
  assign cfg_ready = in_func | in_test;
  assign mode      = state;
  assign tm_active = in_test;
  assign core_i    = in_func ? pad_sync : '0;
  assign tm_i      = in_test ? pad_sync : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pin_en <= '0;
    end else if (cfg_valid && cfg_ready) begin
      pin_en <= cfg_wdata;
    end
  end

  // In guard states pad data freezes so the pins see no glitch while undriven.
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_o  <= '0;
      pad_oe <= '0;
    end else if (in_func) begin
      pad_o  <= core_o;
      pad_oe <= core_oe & pin_en;
    end else if (in_test) begin
      pad_o  <= tm_o;
      pad_oe <= tm_oe & pin_en;
    end else begin
      pad_oe <= '0;
    end
  end

endmodule

// File: tb/tb_padring_ctrl.sv
// Directed self-checking bench for padring_ctrl (SYNC_STAGES=2, GUARD_CYCLES=4).
module tb_padring_ctrl;

  localparam int W = 15;
`ifdef PADRING_TM_DEBOUNCE_EN
  localparam int EXTRA = 8;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         pad_tm_i;
  logic [W-1:0] pad_i;
  logic [W-1:0] pad_o;
  logic [W-1:0] pad_oe;
  logic [W-1:0] core_o;
  logic [W-1:0] core_oe;
  logic [W-1:0] core_i;
  logic [W-1:0] tm_o;
  logic [W-1:0] tm_oe;
  logic [W-1:0] tm_i;
  logic         cfg_valid;
  logic [W-1:0] cfg_wdata;
  logic         cfg_ready;
  logic [1:0]   mode;
  logic         tm_active;

  int checks = 0;
  int errors = 0;

  padring_ctrl #(
    .GPIO_WIDTH      (W),
    .SYNC_STAGES     (2),
    .GUARD_CYCLES    (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pad_tm_i  (pad_tm_i),
    .pad_i     (pad_i),
    .pad_o     (pad_o),
    .pad_oe    (pad_oe),
    .core_o    (core_o),
    .core_oe   (core_oe),
    .core_i    (core_i),
    .tm_o      (tm_o),
    .tm_oe     (tm_oe),
    .tm_i      (tm_i),
    .cfg_valid (cfg_valid),
    .cfg_wdata (cfg_wdata),
    .cfg_ready (cfg_ready),
    .mode      (mode),
    .tm_active (tm_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic tm_level, input logic valid, input logic [W-1:0] wdata);
    pad_tm_i  = tm_level;
    cfg_valid = valid;
    cfg_wdata = wdata;
  endtask

  task automatic waitMode(input logic [1:0] target, input int budget, input string tag);
    int n = 0;
    while (mode !== target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(mode), 32'(target));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    pad_i   = '0;
    core_o  = '0;
    core_oe = 15'h7FFF;
    tm_o    = '0;
    tm_oe   = '0;
    applyStimulus(1'b0, 1'b0, '0);
    repeat (3) tick();
    checkOutput("reset_pad_oe", 32'(pad_oe), 32'h0);
    checkOutput("reset_mode", 32'(mode), 32'h0);
    checkOutput("reset_cfg_ready", 32'(cfg_ready), 32'h1);
    rst = 1'b0;
    tick();
    checkOutput("idle_pad_oe", 32'(pad_oe), 32'h0);
    checkOutput("idle_tm_active", 32'(tm_active), 32'h0);
    checkOutput("idle_core_i", 32'(core_i), 32'h0);

    // pin-enable write in FUNC
    core_o = 15'h5555;
    applyStimulus(1'b0, 1'b1, 15'h00FF);
    tick();
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("pin_en_lag", 32'(pad_oe), 32'h0);
    checkOutput("func_pad_o", 32'(pad_o), 32'h5555);
    tick();
    checkOutput("func_pad_oe", 32'(pad_oe), 32'h00FF);

    // input synchroniser latency
    pad_i = 15'h1234;
    tick();
    checkOutput("core_i_lat1", 32'(core_i), 32'h0);
    tick();
    checkOutput("core_i_lat2", 32'(core_i), 32'h1234);
    checkOutput("tm_i_in_func", 32'(tm_i), 32'h0);

    // FUNC -> TEST
    tm_o  = 15'h2AAA;
    tm_oe = 15'h7FFF;
    applyStimulus(1'b1, 1'b0, '0);
    repeat (2 + EXTRA) tick();
    checkOutput("tm_sync_mode", 32'(mode), 32'h0);
    tick();
    checkOutput("g2t_entry_mode", 32'(mode), 32'h1);
    checkOutput("g2t_first_oe", 32'(pad_oe), 32'h00FF);
    checkOutput("g2t_cfg_ready", 32'(cfg_ready), 32'h0);
    checkOutput("g2t_core_i", 32'(core_i), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("g2t_oe", 32'(pad_oe), 32'h0);
      checkOutput("g2t_hold_o", 32'(pad_o), 32'h5555);
      checkOutput("g2t_mode", 32'(mode), (k == 3) ? 32'h2 : 32'h1);
    end
    checkOutput("test_active", 32'(tm_active), 32'h1);
    checkOutput("test_tm_i", 32'(tm_i), 32'h1234);
    checkOutput("test_core_i", 32'(core_i), 32'h0);
    tick();
    checkOutput("test_pad_oe", 32'(pad_oe), 32'h00FF);
    checkOutput("test_pad_o", 32'(pad_o), 32'h2AAA);
    pad_i = 15'h0F0F;
    tick();
    checkOutput("tm_i_lat1", 32'(tm_i), 32'h1234);
    tick();
    checkOutput("tm_i_lat2", 32'(tm_i), 32'h0F0F);

    // TEST -> FUNC
    applyStimulus(1'b0, 1'b0, '0);
    repeat (2 + EXTRA) tick();
    checkOutput("back_sync_mode", 32'(mode), 32'h2);
    tick();
    checkOutput("g2f_entry_mode", 32'(mode), 32'h3);
    checkOutput("g2f_first_oe", 32'(pad_oe), 32'h00FF);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("g2f_oe", 32'(pad_oe), 32'h0);
      checkOutput("g2f_hold_o", 32'(pad_o), 32'h2AAA);
      checkOutput("g2f_mode", 32'(mode), (k == 3) ? 32'h0 : 32'h3);
    end
    checkOutput("func_core_i", 32'(core_i), 32'h0F0F);
    tick();
    checkOutput("func_again_oe", 32'(pad_oe), 32'h00FF);
    checkOutput("func_again_o", 32'(pad_o), 32'h5555);

    // request dropped one cycle into the guard
    applyStimulus(1'b1, 1'b0, '0);
    repeat (3 + EXTRA) tick();
    checkOutput("drop_g2t_entry", 32'(mode), 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, '0);
    repeat (2) tick();
    checkOutput("drop_guard_runs", 32'(mode), 32'h1);
    tick();
    checkOutput("drop_test_reached", 32'(mode), 32'h2);
    waitMode(2'd3, 30, "drop_g2f_entry");
    repeat (3) tick();
    checkOutput("drop_g2f_last", 32'(mode), 32'h3);
    tick();
    checkOutput("drop_func_resumed", 32'(mode), 32'h0);

    // write held across a guard window
    applyStimulus(1'b1, 1'b0, '0);
    repeat (3 + EXTRA) tick();
    checkOutput("hold_g2t_entry", 32'(mode), 32'h1);
    applyStimulus(1'b1, 1'b1, 15'h7F00);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("hold_cfg_ready_low", 32'(cfg_ready), 32'h0);
    end
    tick();
    checkOutput("hold_test_mode", 32'(mode), 32'h2);
    checkOutput("hold_cfg_ready_high", 32'(cfg_ready), 32'h1);
    tick();
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("hold_old_mask", 32'(pad_oe), 32'h00FF);
    tick();
    checkOutput("hold_new_mask", 32'(pad_oe), 32'h7F00);

    // reset while in TEST
    applyStimulus(1'b0, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_test_mode", 32'(mode), 32'h0);
    checkOutput("rst_test_oe", 32'(pad_oe), 32'h0);
    checkOutput("rst_test_active", 32'(tm_active), 32'h0);
    checkOutput("rst_test_tm_i", 32'(tm_i), 32'h0);
    tick();
    checkOutput("rst_pin_en_clear", 32'(pad_oe), 32'h0);
    checkOutput("rst_stays_func", 32'(mode), 32'h0);

`ifdef PADRING_TM_DEBOUNCE_EN
    begin
      logic saw;
      saw = 1'b0;
      applyStimulus(1'b1, 1'b0, '0);
      repeat (5) begin tick(); if (mode !== 2'd0) saw = 1'b1; end
      applyStimulus(1'b0, 1'b0, '0);
      repeat (20) begin tick(); if (mode !== 2'd0) saw = 1'b1; end
      checkOutput("db_short_pulse", 32'(saw), 32'h0);
      saw = 1'b0;
      applyStimulus(1'b1, 1'b0, '0);
      repeat (10) begin tick(); if (mode === 2'd1) saw = 1'b1; end
      applyStimulus(1'b0, 1'b0, '0);
      repeat (20) begin tick(); if (mode === 2'd1) saw = 1'b1; end
      checkOutput("db_long_pulse", 32'(saw), 32'h1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/padring_ctrl.md
# padring_ctrl

Parametrised, clocked pad-ring controller between the chip-level GPIO pads and the core. It arbitrates every pad between the functional core path and the test-mode path, selected by the test-mode pad. Mode changes are break-before-make: all output enables drop for a guard window before the new owner drives. It also synchronises pad inputs, provides a per-pin enable register behind a valid/ready write port, and registers all pad-facing outputs.

## Interface
Parameters:
- GPIO_WIDTH, 15, number of GPIO pads handled.
- SYNC_STAGES, 2, flops in each input synchroniser; legal range 2..4.
- GUARD_CYCLES, 4, cycles with all pad_oe low during a mode switch; legal range 1..255.
- DEBOUNCE_CYCLES, 8, stable cycles required on the test-mode request; used only with the debounce macro.

Ports:
- Clocking is fixed: one clock, `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- pad_tm_i  in  1  raw asynchronous test-mode pad level.
- pad_i  in  GPIO_WIDTH  raw pad input levels.
- pad_o  out  GPIO_WIDTH  registered pad output data.
- pad_oe  out  GPIO_WIDTH  registered pad output enable, 1 = drive.
- core_o / core_oe  in  GPIO_WIDTH each  functional data and enable from the core.
- core_i  out  GPIO_WIDTH  synchronised pad inputs to the core.
- tm_o / tm_oe  in  GPIO_WIDTH each  test-path data and enable.
- tm_i  out  GPIO_WIDTH  synchronised pad inputs to the test path.
- cfg_valid  in  1  pin-enable write request.
- cfg_wdata  in  GPIO_WIDTH  new pin-enable mask.
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
- mode  out  2  current FSM state encoding.
- tm_active  out  1  high only in state TEST.

## Operation
- pad_tm_i passes through a SYNC_STAGES synchroniser; the result is tm_req.
- All GPIO_WIDTH pad_i bits pass through identical synchronisers.
- FSM states: FUNC=0, GUARD_TO_TEST=1, TEST=2, GUARD_TO_FUNC=3.
  - FUNC: tm_req=1 moves to GUARD_TO_TEST.
  - GUARD_TO_TEST: guard counter loads GUARD_CYCLES-1 on entry and counts down; at 0 the FSM moves to TEST.
  - TEST: tm_req=0 moves to GUARD_TO_FUNC.
  - GUARD_TO_FUNC: same guard behaviour, then moves to FUNC.
- A guard window always completes, even if tm_req toggles mid-guard. The FSM re-evaluates tm_req only on arrival in FUNC or TEST.
- Output mux:
  - FUNC: pad_o=core_o, pad_oe=core_oe & pin_en.
  - TEST: pad_o=tm_o, pad_oe=tm_oe & pin_en.
  - Guard states: pad_oe=0 and pad_o holds its previous value.
- Input routing:
  - core_i carries the synchronised inputs only in FUNC, otherwise 0.
  - tm_i carries the synchronised inputs only in TEST, otherwise 0.
- pin_en register:
  - cfg_ready=1 in FUNC and TEST, 0 in guard states.
  - An accepted write updates pin_en on the next edge; the new mask affects pad_oe one cycle after that.
- Reset values: state FUNC, pin_en=0, guard counter 0, synchroniser flops 0, pad_o=0, pad_oe=0, core_i=0, tm_i=0, mode=0, tm_active=0, cfg_ready=1 from the first cycle after reset.
- An rst asserted mid-guard or in TEST returns the block to FUNC with all enables low in the following cycle.

## Timing
- Input latency: pad_i to core_i/tm_i is SYNC_STAGES cycles.
- Mode-switch latency: a pad_tm_i edge reaches tm_req after SYNC_STAGES cycles; the state leaves FUNC/TEST on the next edge.
- Guard length: pad_oe is 0 for exactly GUARD_CYCLES cycles plus the one-cycle output register.
- Output latency: core_o/tm_o/oe to pad_o/pad_oe is 1 cycle.
- Handshake: cfg_valid may be held high across a guard window. The write completes on the first cycle of FUNC or TEST; cfg_wdata must stay stable while cfg_valid is high.

## Configuration
- PADRING_TM_DEBOUNCE_EN defined:
  - A counter requires tm_req to hold a new value for DEBOUNCE_CYCLES consecutive cycles before it becomes tm_req_db, which drives the FSM.
  - Any toggle restarts the count; the counter resets to 0.
- PADRING_TM_DEBOUNCE_EN undefined: the FSM uses tm_req directly and no debounce logic is built.

## Structure
- padring_pkg holds the state enum (FUNC, GUARD_TO_TEST, TEST, GUARD_TO_FUNC) and the 2-bit mode width constant.
- One sub-module, padring_sync: a single-bit, SYNC_STAGES-deep synchroniser with synchronous reset to 0. It is instantiated for pad_tm_i and, via generate, for each pad_i bit.

## Test plan
- Power-on: rst high 3 cycles, core_oe=15'h7FFF -> pad_oe=0 (pin_en=0), mode=0, cfg_ready=1.
- Write 15'h00FF, core_o=15'h5555, core_oe=15'h7FFF in FUNC -> pad_oe=15'h00FF two cycles after the handshake, pad_o=15'h5555.
- Raise pad_tm_i (no debounce, SYNC_STAGES=2, GUARD_CYCLES=4) -> pad_oe=0 for 4 cycles, then tm_active=1, pad_o=tm_o, core_i=0, tm_i follows pad_i after 2 cycles.
- Drop pad_tm_i 1 cycle into GUARD_TO_TEST -> guard completes, TEST entered, then GUARD_TO_FUNC runs 4 cycles, FUNC resumes.
- cfg_valid held during a guard -> cfg_ready=0 throughout; the write completes on the first TEST cycle.
- With PADRING_TM_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: 5-cycle pulse on pad_tm_i -> no state change. A 10-cycle pulse -> GUARD_TO_TEST entered.
